// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through all four input vectors, waits a programmable
// settle time before each sample and scores the gate against a truth table.
module gate_sweep_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [3:0] expect_i,
   input  logic       gate_out_i,
   output logic       gate_in0_o,
   output logic       gate_in1_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       pass_o,
   output logic [3:0] fail_mask_o,
   output logic [2:0] err_count_o
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned VEC_N = 4;
   localparam int unsigned ERR_W = 3;

   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [IDX_W-1:0]   idx_q,       idx_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [VEC_N-1:0]   expect_q,    expect_d;
   logic [VEC_N-1:0]   fail_mask_q, fail_mask_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
   logic               pass_q,      pass_d;
   logic [IDX_W-1:0]   gate_in_q,   gate_in_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               mismatch_c;

   // State and output registers; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         expect_q    <= '0;
         fail_mask_q <= '0;
         err_count_q <= '0;
         pass_q      <= 1'b0;
         gate_in_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         expect_q    <= expect_d;
         fail_mask_q <= fail_mask_d;
         err_count_q <= err_count_d;
         pass_q      <= pass_d;
         gate_in_q   <= gate_in_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and result update; outputs are derived from the next state
   // so that the registered gate inputs track idx with no extra cycle.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      expect_d    = expect_q;
      fail_mask_d = fail_mask_q;
      err_count_d = err_count_q;
      pass_d      = pass_q;
      mismatch_c  = (gate_out_i != expect_q[idx_q]);

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d     = ST_DRIVE;
               idx_d       = '0;
               cnt_d       = '0;
               expect_d    = expect_i;
               fail_mask_d = '0;
               err_count_d = '0;
               pass_d      = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q < SETTLE_C) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               if (mismatch_c) begin
                  fail_mask_d[idx_q] = 1'b1;
                  err_count_d        = err_count_q + ERR_W'(1);
               end
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
                  pass_d  = (err_count_d == ERR_W'(0));
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  cnt_d = '0;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d    = (state_d == ST_DRIVE);
      done_d    = (state_d == ST_DONE);
      gate_in_d = busy_d ? idx_d : IDX_W'(0);
   end

   assign gate_in0_o  = gate_in_q[0];
   assign gate_in1_o  = gate_in_q[1];
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign fail_mask_o = fail_mask_q;
   assign err_count_o = err_count_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0),
// each driving a behavioural gate model selected per sweep.
module tb_gate_sweep_ctrl;

   localparam int G_XNOR = 0;
   localparam int G_AND  = 1;
   localparam int G_ZERO = 2;
   localparam int G_XOR  = 3;
   localparam int G_OR   = 4;

   typedef struct {
      logic       pass;
      logic [3:0] mask;
      logic [2:0] cnt;
      int         blen;
      int         gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_w[2];
   logic [3:0] exp_w[2];
   logic       gout_w[2];
   logic       in0_w[2];
   logic       in1_w[2];
   logic       busy_w[2];
   logic       done_w[2];
   logic       pass_w[2];
   logic [3:0] mask_w[2];
   logic [2:0] cnt_w[2];
   int         gsel[2];

   exp_t       sb0[$];
   exp_t       sb1[$];
   exp_t       mon_e;
   bit         have;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int         busy_run[2];
   int         last_done[2];
   logic       prev_done[2];
   logic       held_pass[2];
   logic [3:0] held_mask[2];
   logic [2:0] held_cnt[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic gfun(input int g, input logic a, input logic b);
      case (g)
         G_XNOR:  return ~(a ^ b);
         G_AND:   return a & b;
         G_XOR:   return a ^ b;
         G_OR:    return a | b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sp1(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   always_comb begin
      for (int d = 0; d < 2; d++) gout_w[d] = gfun(gsel[d], in0_w[d], in1_w[d]);
   end

   gate_sweep_ctrl #(.SETTLE(1)) u_dut_s1 (
      .clk(clk), .rst_n(rst_n), .start_i(start_w[0]), .expect_i(exp_w[0]),
      .gate_out_i(gout_w[0]), .gate_in0_o(in0_w[0]), .gate_in1_o(in1_w[0]),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
      .fail_mask_o(mask_w[0]), .err_count_o(cnt_w[0])
   );

   gate_sweep_ctrl #(.SETTLE(0)) u_dut_s0 (
      .clk(clk), .rst_n(rst_n), .start_i(start_w[1]), .expect_i(exp_w[1]),
      .gate_out_i(gout_w[1]), .gate_in0_o(in0_w[1]), .gate_in1_o(in1_w[1]),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
      .fail_mask_o(mask_w[1]), .err_count_o(cnt_w[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: vector order and busy length per sweep, results on done, hold while idle.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            busy_run[d]  = 0;
            last_done[d] = 0;
            prev_done[d] = 1'b0;
            held_pass[d] = 1'b0;
            held_mask[d] = 4'b0;
            held_cnt[d]  = 3'd0;
         end else begin
            if (busy_w[d]) begin
               chk($sformatf("d%0d_vector", d), int'({in1_w[d], in0_w[d]}), busy_run[d] / sp1(d));
               chk($sformatf("d%0d_pass_cleared", d), int'(pass_w[d]), 0);
               busy_run[d]++;
            end else begin
               chk($sformatf("d%0d_idle_inputs", d), int'({in1_w[d], in0_w[d]}), 0);
            end
            if (done_w[d]) begin
               chk($sformatf("d%0d_done_width", d), int'(prev_done[d]), 0);
               have = 1'b0;
               if (d == 0 && sb0.size() > 0) begin
                  mon_e = sb0.pop_front();
                  have  = 1'b1;
               end else if (d == 1 && sb1.size() > 0) begin
                  mon_e = sb1.pop_front();
                  have  = 1'b1;
               end
               if (!have) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL d%0d_unexpected_done: got done=1 expected no sweep (cycle %0d)", d, cyc);
               end else begin
                  chk($sformatf("d%0d_pass", d), int'(pass_w[d]), int'(mon_e.pass));
                  chk($sformatf("d%0d_fail_mask", d), int'(mask_w[d]), int'(mon_e.mask));
                  chk($sformatf("d%0d_err_count", d), int'(cnt_w[d]), int'(mon_e.cnt));
                  chk($sformatf("d%0d_busy_len", d), busy_run[d], mon_e.blen);
                  if (mon_e.gap > 0) chk($sformatf("d%0d_sweep_period", d), cyc - last_done[d], mon_e.gap);
                  held_pass[d] = mon_e.pass;
                  held_mask[d] = mon_e.mask;
                  held_cnt[d]  = mon_e.cnt;
               end
               last_done[d] = cyc;
               busy_run[d]  = 0;
            end else if (!busy_w[d]) begin
               chk($sformatf("d%0d_hold_pass", d), int'(pass_w[d]), int'(held_pass[d]));
               chk($sformatf("d%0d_hold_mask", d), int'(mask_w[d]), int'(held_mask[d]));
               chk($sformatf("d%0d_hold_count", d), int'(cnt_w[d]), int'(held_cnt[d]));
            end
            prev_done[d] = done_w[d];
         end
      end
   end

   // One start pulse, expected result queued at issue, then wait out the sweep.
   task automatic run(input int d, input int g, input logic [3:0] tt, input exp_t e);
      gsel[d]    = g;
      exp_w[d]   = tt;
      start_w[d] = 1'b1;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
      @(posedge clk); #1;
      start_w[d] = 1'b0;
      repeat (4 * sp1(d) + 4) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_w[d] = 1'b0;
         exp_w[d]   = 4'b0;
         gsel[d]    = G_XNOR;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_in0", d), int'(in0_w[d]), 0);
         chk($sformatf("d%0d_rst_in1", d), int'(in1_w[d]), 0);
         chk($sformatf("d%0d_rst_busy", d), int'(busy_w[d]), 0);
         chk($sformatf("d%0d_rst_done", d), int'(done_w[d]), 0);
         chk($sformatf("d%0d_rst_pass", d), int'(pass_w[d]), 0);
         chk($sformatf("d%0d_rst_mask", d), int'(mask_w[d]), 0);
         chk($sformatf("d%0d_rst_count", d), int'(cnt_w[d]), 0);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run(0, G_XNOR, 4'b1001, '{1'b1, 4'b0000, 3'd0, 8, 0});
      run(0, G_AND,  4'b1001, '{1'b0, 4'b0001, 3'd1, 8, 0});
      repeat (6) @(posedge clk);
      #1;
      run(0, G_ZERO, 4'b1111, '{1'b0, 4'b1111, 3'd4, 8, 0});
      run(0, G_OR,   4'b1001, '{1'b0, 4'b0111, 3'd3, 8, 0});

      // expect changed and a stray start issued mid-sweep
      gsel[0]    = G_XOR;
      exp_w[0]   = 4'b0110;
      start_w[0] = 1'b1;
      sb0.push_back('{1'b1, 4'b0000, 3'd0, 8, 0});
      @(posedge clk); #1;
      start_w[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_w[0]   = 4'b0000;
      start_w[0] = 1'b1;
      @(posedge clk); #1;
      start_w[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // start held high: three back-to-back sweeps, 10 cycles apart
      gsel[0]    = G_XNOR;
      exp_w[0]   = 4'b1001;
      start_w[0] = 1'b1;
      sb0.push_back('{1'b1, 4'b0000, 3'd0, 8, 0});
      sb0.push_back('{1'b1, 4'b0000, 3'd0, 8, 10});
      sb0.push_back('{1'b1, 4'b0000, 3'd0, 8, 10});
      repeat (21) @(posedge clk);
      #1;
      start_w[0] = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      // SETTLE = 0 instance
      run(1, G_XNOR, 4'b1001, '{1'b1, 4'b0000, 3'd0, 4, 0});
      run(1, G_AND,  4'b1001, '{1'b0, 4'b0001, 3'd1, 4, 0});

      // reset sampled at E0+3 aborts the sweep with no done
      run(0, G_AND, 4'b1001, '{1'b0, 4'b0001, 3'd1, 8, 0});
      gsel[0]    = G_ZERO;
      exp_w[0]   = 4'b1111;
      start_w[0] = 1'b1;
      @(posedge clk); #1;
      start_w[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_in0", int'(in0_w[0]), 0);
      chk("abort_in1", int'(in1_w[0]), 0);
      chk("abort_busy", int'(busy_w[0]), 0);
      chk("abort_done", int'(done_w[0]), 0);
      chk("abort_pass", int'(pass_w[0]), 0);
      chk("abort_mask", int'(mask_w[0]), 0);
      chk("abort_count", int'(cnt_w[0]), 0);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      run(0, G_XNOR, 4'b1001, '{1'b1, 4'b0000, 3'd0, 8, 0});

      repeat (4) @(posedge clk);
      #1;
      chk("sb0_left", sb0.size(), 0);
      chk("sb1_left", sb1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
